// File: rtl/frame_sequencer_if.sv
// Phase request/acknowledge bus between the frame sequencer and the game update logic.
// The sequencer is the master: it raises req with a phase index and waits for ack.
interface frame_sequencer_if #(
  parameter int PW = 4
) ();
  logic          req;
  logic          ack;
  logic [PW-1:0] phase;

  modport master (output req, output phase, input ack);
  modport slave  (input req, input phase, output ack);
endinterface

// File: rtl/frame_sequencer.sv
// Runs one game-update frame (a fixed series of req/ack phases) per 60 Hz tick, counts frames
// and flags dropped ticks. Optional ack watchdog enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int PW         = 4,
  parameter int FW         = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                tick,
  input  logic                overrun_clr,
  frame_sequencer_if.master   gbus,
  output logic                busy,
  output logic                frame_done,
  output logic [FW-1:0]       frame_cnt,
  output logic                overrun,
  output logic [7:0]          overrun_cnt,
  output logic                timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] phase_q;
  logic          start;
  logic          accept;
  logic          last;
  logic          drop;
  logic          wd_expire;

  assign last = (phase_q == PW'(NUM_PHASES - 1));
  assign drop = tick && (state != IDLE);

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // ISSUE is always entered from IDLE or GAP, so clearing outside ISSUE restarts it per phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (state != ISSUE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == ISSUE) && (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout <= 1'b0;
    end else if (wd_expire && !gbus.ack) begin
      timeout <= 1'b1;
    end else if (overrun_clr) begin
      timeout <= 1'b0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = ISSUE;
          start     = 1'b1;
        end
      end
      ISSUE: begin
        if (gbus.ack || wd_expire) begin
          accept    = 1'b1;
          state_nxt = last ? IDLE : GAP;
        end
      end
      GAP:     state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase advances on leaving GAP so it stays stable for the whole ISSUE window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= accept && last;
      if (start || (accept && last)) begin
        phase_q <= '0;
      end else if (state == GAP) begin
        phase_q <= phase_q + 1'b1;
      end
      if (accept && last) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // A fresh drop beats a simultaneous clear, leaving a count of one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (overrun_clr) begin
        overrun_cnt <= 8'd1;
      end else if (overrun_cnt != 8'd255) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end else if (overrun_clr) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end
  end

  assign gbus.req   = (state == ISSUE);
  assign gbus.phase = phase_q;
  assign busy       = (state != IDLE);

endmodule
